branch_predictor: RTL



---
 rtl/branch_predictor_pkg.sv | 38 +++
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 103 ++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types, constants and index/tag helpers for the branch predictor.
package branch_predictor_pkg;

  // Default geometry; the entry struct below is sized from these constants,
  // so the top-level parameters must keep the same values.
  localparam int BP_DATA_WIDTH  = 64;
  localparam int BP_BTB_ENTRIES = 16;
  localparam int BP_TAG_BITS    = 10;
  localparam int BP_CTR_BITS    = 2;
  localparam int BP_PERF_WIDTH  = 32;

  // Weak states: MSB set with the rest clear, and the value just below it.
  localparam logic [BP_CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(BP_CTR_BITS-1){1'b0}}};
  localparam logic [BP_CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(BP_CTR_BITS-1){1'b1}}};

  typedef struct packed {
    logic                     valid;
    logic [BP_TAG_BITS-1:0]   tag;
    logic [BP_DATA_WIDTH-1:0] target;
    logic [BP_CTR_BITS-1:0]   ctr;
  } btb_entry_t;

  // Entry index: PC bits [idx_w+1:2]; the low two bits are ignored.
  function automatic logic [31:0] btb_idx(input logic [63:0] pc, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag: the tag_bits PC bits directly above the index field.
  function automatic logic [31:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w,
                                          input int unsigned tag_bits);
    logic [63:0] mask;
    mask = (64'd1 << tag_bits) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-update and perf-counter signals of the branch predictor.
// There is no handshake: the lookup is combinational and always answered, and an
// update is accepted exactly in the cycles where upd_valid_i=1 and stall_i=0.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int PERF_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] lookup_pc_i;
  logic                  pred_taken_o;
  logic [DATA_WIDTH-1:0] pred_target_o;
  logic                  upd_valid_i;
  logic [DATA_WIDTH-1:0] upd_pc_i;
  logic                  upd_taken_i;
  logic [DATA_WIDTH-1:0] upd_target_i;
  logic                  upd_mispredict_i;
  logic                  stall_i;
  logic [PERF_WIDTH-1:0] perf_branches_o;
  logic [PERF_WIDTH-1:0] perf_mispredicts_o;

  // Pipeline side: drives the fetch PC and resolved outcomes.
  modport master (
    output lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_mispredict_i, stall_i,
    input  pred_taken_o, pred_target_o, perf_branches_o, perf_mispredicts_o
  );

  // Predictor side.
  modport slave (
    input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_mispredict_i, stall_i,
    output pred_taken_o, pred_target_o, perf_branches_o, perf_mispredicts_o
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic of an up/down counter that sticks at zero and at all-ones.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] value_o
);

  // Step by one in the requested direction unless already at that end.
  always_comb begin
    value_o = value_i;
    if (inc_i && !dec_i && (value_i != {WIDTH{1'b1}})) begin
      value_o = value_i + WIDTH'(1);
    end else if (dec_i && !inc_i && (value_i != '0)) begin
      value_o = value_i - WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH  = BP_DATA_WIDTH,
  parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
  parameter int TAG_BITS    = BP_TAG_BITS,
  parameter int CTR_BITS    = BP_CTR_BITS,
  parameter int PERF_WIDTH  = BP_PERF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t            entries_q [BTB_ENTRIES];
  logic [IDX_W-1:0]      lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  btb_entry_t            lk_e, up_e;
  logic                  lk_hit, up_hit, upd_eff;
  logic [CTR_BITS-1:0]   ctr_d;
  logic [PERF_WIDTH-1:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

  // Fetch lookup: reads the registered table, so an update in the same cycle is not seen.
  always_comb begin
    lk_idx = IDX_W'(btb_idx(64'(bp.lookup_pc_i), IDX_W));
    lk_tag = TAG_BITS'(btb_tag(64'(bp.lookup_pc_i), IDX_W, TAG_BITS));
    lk_e   = entries_q[lk_idx];
    lk_hit = lk_e.valid && (lk_e.tag == lk_tag);
    bp.pred_taken_o  = lk_hit && lk_e.ctr[CTR_BITS-1];
    bp.pred_target_o = bp.pred_taken_o ? lk_e.target : bp.lookup_pc_i + DATA_WIDTH'(4);
  end

  // Decode the update slot and decide whether it lands this cycle.
  always_comb begin
    up_idx  = IDX_W'(btb_idx(64'(bp.upd_pc_i), IDX_W));
    up_tag  = TAG_BITS'(btb_tag(64'(bp.upd_pc_i), IDX_W, TAG_BITS));
    up_e    = entries_q[up_idx];
    up_hit  = up_e.valid && (up_e.tag == up_tag);
    upd_eff = bp.upd_valid_i && !bp.stall_i;
  end

  // Only one entry trains per cycle, so one direction-counter adder is enough.
  sat_counter #(.WIDTH(CTR_BITS)) u_dir_ctr (
    .value_i (up_e.ctr),
    .inc_i   (bp.upd_taken_i),
    .dec_i   (!bp.upd_taken_i),
    .value_o (ctr_d)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_perf_br (
    .value_i (perf_br_q),
    .inc_i   (upd_eff),
    .dec_i   (1'b0),
    .value_o (perf_br_d)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_perf_mis (
    .value_i (perf_mis_q),
    .inc_i   (upd_eff && bp.upd_mispredict_i),
    .dec_i   (1'b0),
    .value_o (perf_mis_d)
  );

  // Table write: train on hit, allocate on taken miss; tag/target are gated by valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].ctr   <= CTR_WEAK_NT;
      end
    end else if (upd_eff) begin
      if (up_hit) begin
        entries_q[up_idx].ctr <= ctr_d;
        if (bp.upd_taken_i) begin
          entries_q[up_idx].target <= bp.upd_target_i;
        end
      end else if (bp.upd_taken_i) begin
        entries_q[up_idx].valid  <= 1'b1;
        entries_q[up_idx].tag    <= up_tag;
        entries_q[up_idx].target <= bp.upd_target_i;
        entries_q[up_idx].ctr    <= CTR_WEAK_T;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign bp.perf_branches_o    = perf_br_q;
  assign bp.perf_mispredicts_o = perf_mis_q;

endmodule
